// File: rtl/user_ip_apb_bridge_pkg.sv
// Shared constants for the native-bus to APB4 bridge feeding the user IP slots.
// State encoding, timeout counter width and fixed bus attributes.
package user_ip_apb_bridge_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TO_CNT_W = 16;

    localparam logic [2:0] PPROT_VAL = 3'b000;

    // A single-slot build still needs a 1-bit slot register.
    function automatic int unsigned slot_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_ip_apb_rsp_mux.sv
// Combinational selection of the addressed slot's prdata/pready/pslverr.
module user_ip_apb_rsp_mux
    import user_ip_apb_bridge_pkg::*;
#(
    parameter int unsigned SLV_NUM = 8,
    parameter int unsigned SLOT_W  = 3
) (
    input  logic [SLOT_W-1:0]         i_slot,
    input  logic [DATA_W*SLV_NUM-1:0] i_prdata,
    input  logic [SLV_NUM-1:0]        i_pready,
    input  logic [SLV_NUM-1:0]        i_pslverr,
    output logic [DATA_W-1:0]         o_prdata_c,
    output logic                      o_pready_c,
    output logic                      o_pslverr_c
);

    always_comb begin
        o_prdata_c  = '0;
        o_pready_c  = 1'b0;
        o_pslverr_c = 1'b0;
        for (int k = 0; k < int'(SLV_NUM); k++) begin
            if (i_slot == SLOT_W'(k)) begin
                o_prdata_c  = i_prdata[DATA_W*k +: DATA_W];
                o_pready_c  = i_pready[k];
                o_pslverr_c = i_pslverr[k];
            end
        end
    end

endmodule

// File: rtl/user_ip_apb_bridge.sv
// Native valid/ready request to single APB4 transfer bridge for the user IP slots,
// with per-slot psel, pready timeout and a sticky error flag.
module user_ip_apb_bridge
    import user_ip_apb_bridge_pkg::*;
#(
    parameter int unsigned SLV_NUM        = 8,
    parameter int unsigned SLV_ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_valid_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               mem_wdata_i,
    input  logic [3:0]                mem_wstrb_i,
    output logic                      mem_ready_o,
    output logic [31:0]               mem_rdata_o,
    output logic [31:0]               paddr_o,
    output logic                      pwrite_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pstrb_o,
    output logic [2:0]                pprot_o,
    output logic [SLV_NUM-1:0]        psel_o,
    output logic                      penable_o,
    input  logic [DATA_W*SLV_NUM-1:0] prdata_i,
    input  logic [SLV_NUM-1:0]        pready_i,
    input  logic [SLV_NUM-1:0]        pslverr_i,
    output logic                      err_o,
    input  logic                      err_clr_i
);

    localparam int unsigned IDX_W  = $clog2(SLV_NUM);
    localparam int unsigned SLOT_W = slot_width(SLV_NUM);
    localparam int unsigned HI     = SLV_ADDR_WIDTH + IDX_W;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [31:0]         r_paddr;
    logic [31:0]         r_pwdata;
    logic [3:0]          r_pstrb;
    logic                r_pwrite;
    logic [SLV_NUM-1:0]  r_psel;
    logic                r_penable;
    logic                r_mem_ready;
    logic [31:0]         r_mem_rdata;
    logic                r_err;
    logic [TO_CNT_W-1:0] r_to_cnt;

    logic                w_hit;
    logic [SLOT_W-1:0]   w_slot_req;
    logic                w_start;
    logic                w_done;
    logic                w_timeout;
    logic                w_err_set;
    logic [DATA_W-1:0]   w_prdata;
    logic                w_pready;
    logic                w_pslverr;

    assign w_hit = (mem_addr_i[31:HI] == BASE_ADDR[31:HI]);

    generate
        if (IDX_W == 0) begin : g_single_slot
            assign w_slot_req = '0;
        end else begin : g_multi_slot
            assign w_slot_req = mem_addr_i[SLV_ADDR_WIDTH +: IDX_W];
        end
    endgenerate

    user_ip_apb_rsp_mux #(
        .SLV_NUM (SLV_NUM),
        .SLOT_W  (SLOT_W)
    ) u_rsp_mux (
        .i_slot      (r_slot),
        .i_prdata    (prdata_i),
        .i_pready    (pready_i),
        .i_pslverr   (pslverr_i),
        .o_prdata_c  (w_prdata),
        .o_pready_c  (w_pready),
        .o_pslverr_c (w_pslverr)
    );

    // Next state; pready in the same ACCESS cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid_i && w_hit) begin
                    w_state_nxt = S_SETUP;
                    w_start     = 1'b1;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (w_pready) begin
                    w_state_nxt = S_RESP;
                    w_done      = 1'b1;
                end else if (r_to_cnt == TO_CNT_W'(TIMEOUT)) begin
                    w_state_nxt = S_RESP;
                    w_timeout   = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_err_set = w_timeout || (w_done && w_pslverr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, APB phase outputs, response and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot      <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_mem_ready <= w_done || w_timeout;
            if (w_start) begin
                r_slot   <= w_slot_req;
                r_paddr  <= mem_addr_i;
                r_pwdata <= mem_wdata_i;
                r_pstrb  <= mem_wstrb_i;
                r_pwrite <= |mem_wstrb_i;
                r_psel   <= SLV_NUM'(1) << w_slot_req;
                r_to_cnt <= '0;
            end
            if (r_state == S_SETUP) begin
                r_penable <= 1'b1;
            end
            if (r_state == S_ACCESS && !w_pready && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end
            if (w_done || w_timeout) begin
                r_psel      <= '0;
                r_penable   <= 1'b0;
                r_mem_rdata <= (w_done && !r_pwrite) ? w_prdata : '0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign mem_ready_o = r_mem_ready;
    assign mem_rdata_o = r_mem_rdata;
    assign paddr_o     = r_paddr;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;
    assign pprot_o     = PPROT_VAL;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign err_o       = r_err;

endmodule
